// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake and APB bus signals used by apb_master.
// The master modport is the requester-side APB master's view; the slave modport is
// the opposite view, for the requester/slave side (testbench or integration glue).
interface apb_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Requester command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Requester response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB bus
    logic              Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pready;
    logic              Pslverr;
    logic [DATA_W-1:0] Prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  Pready, Pslverr, Prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output Pready, Pslverr, Prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: turns a single command/response handshake into APB SETUP/ACCESS
// transfers to one slave. All APB and response outputs are registered; cmd_ready
// is combinational (IDLE and out of reset).
// Optional macro APB_TIMEOUT_EN: adds an ACCESS watchdog that aborts a transfer
// after TIMEOUT_CYCLES wait cycles and reports it with rsp_err/rsp_timeout.
module apb_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               Pclk,
    input  logic               Prst_n,
    apb_master_if.master       io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;

    logic              r_psel,        w_psel_nxt;
    logic              r_penable,     w_penable_nxt;
    logic              r_pwrite,      w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic              r_rsp_timeout, w_rsp_timeout_nxt;

    logic              w_timeout_hit;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    // Limit is hit on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_timeout_hit = (r_state == ST_ACCESS) && !io_bus.Pready &&
                           (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog count: cleared on SETUP entry, advanced by each ACCESS wait cycle.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_IDLE && io_bus.cmd_valid) begin
            w_cnt_nxt = '0;
        end else if (r_state == ST_ACCESS && !io_bus.Pready) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Pclk) begin
        if (!Prst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic w_unused_cfg;

    // No watchdog: ACCESS waits for Pready indefinitely.
    assign w_timeout_hit = 1'b0;
    assign w_unused_cfg  = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        w_state_nxt       = r_state;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;

        unique case (r_state)
            ST_IDLE: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                if (io_bus.cmd_valid) begin
                    w_state_nxt  = ST_SETUP;
                    w_psel_nxt   = 1'b1;
                    w_pwrite_nxt = io_bus.cmd_write;
                    w_paddr_nxt  = io_bus.cmd_addr;
                    w_pwdata_nxt = io_bus.cmd_write ? io_bus.cmd_wdata : '0;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (io_bus.Pready) begin
                    w_state_nxt       = ST_IDLE;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = io_bus.Pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                    if (!r_pwrite) begin
                        w_rsp_rdata_nxt = io_bus.Prdata;
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt       = ST_IDLE;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Pclk) begin
        if (!Prst_n) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign io_bus.cmd_ready   = (r_state == ST_IDLE) && Prst_n;
    assign io_bus.Pselx       = r_psel;
    assign io_bus.Penable     = r_penable;
    assign io_bus.Pwrite      = r_pwrite;
    assign io_bus.Paddr       = r_paddr;
    assign io_bus.Pwdata      = r_pwdata;
    assign io_bus.rsp_valid   = r_rsp_valid;
    assign io_bus.rsp_rdata   = r_rsp_rdata;
    assign io_bus.rsp_err     = r_rsp_err;
    assign io_bus.rsp_timeout = r_rsp_timeout;

endmodule
